// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between an instruction-cache
// miss port (I) and a data port (D).
//   I requests are always block fills. D requests are block fills (d_we=0) or
//   single-word writes (d_we=1). A fill issues BLK_WORDS back-to-back reads
//   starting at the block-aligned base address. Returned words are forwarded to
//   the owner with their index in the block.
// Parameters:
//   MEM_LAT   - fixed memory read latency (issue to mem_rvalid), >= 1
//   BLK_WORDS - 16-bit words per block fill, power of 2, <= 16
// Ports:
//   clk, rst_n                         - clock, async active-low reset
//   i_req, i_addr                      - I miss request / byte address
//   d_req, d_we, d_addr, d_wdata       - D request, write select, address, data
//   i_fill_valid, d_fill_valid         - returned word valid, per requester
//   fill_data, fill_idx                - returned word and its block index
//   i_done, d_done, busy               - completion pulses, arbiter busy
//   mem_en, mem_wr, mem_addr,
//   mem_wdata, mem_rdata, mem_rvalid   - main memory interface
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise D has fixed priority.
module mem_arbiter #(
  parameter int MEM_LAT   = 4,
  parameter int BLK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_fill_valid,
  output logic        d_fill_valid,
  output logic [15:0] fill_data,
  output logic [3:0]  fill_idx,
  output logic        i_done,
  output logic        d_done,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic        OWN_I     = 1'b0;
  localparam logic        OWN_D     = 1'b1;
  localparam int          OFS_BITS  = $clog2(BLK_WORDS * 2);
  localparam logic [15:0] BASE_MASK = 16'(~((32'd1 << OFS_BITS) - 32'd1));
  localparam logic [3:0]  LAST_IDX  = 4'(BLK_WORDS - 1);

  // Reject parameter values the counters and address masking cannot handle.
  generate
    if (MEM_LAT < 1 || BLK_WORDS < 1 || BLK_WORDS > 16 ||
        (BLK_WORDS & (BLK_WORDS - 1)) != 0) begin : g_bad_param
      $error("mem_arbiter: unsupported MEM_LAT/BLK_WORDS");
    end
  endgenerate

  state_t     state_r;
  logic       owner_r;
  logic [3:0] issue_cnt_r;
  logic [3:0] ret_cnt_r;
  logic       prio_d_s;
  logic       grant_d_s;
  logic       grant_i_s;
  logic       fill_active_s;

`ifdef MEM_ARBITER_RR_EN
  // Most recently granted requester; starts as I so that D wins first.
  logic rr_last_r;

  // Track the last grant for round-robin tie breaking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r <= OWN_I;
    end else if (grant_d_s || grant_i_s) begin
      rr_last_r <= grant_d_s ? OWN_D : OWN_I;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

  assign prio_d_s = (rr_last_r == OWN_I);
`else
  assign prio_d_s = 1'b1;
`endif

  // Arbitration: only evaluated in IDLE; D wins a tie when it has priority.
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    if (state_r == IDLE) begin
      grant_d_s = d_req && (!i_req || prio_d_s);
      grant_i_s = i_req && !grant_d_s;
    end else begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
    end
  end

  // A return is only meaningful while a fill is outstanding.
  always_comb begin
    fill_active_s = 1'b0;
    case (state_r)
      ISSUE, DRAIN: fill_active_s = mem_rvalid;
      default:      fill_active_s = 1'b0;
    endcase
  end

  // Route the returned word to the current owner.
  always_comb begin
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_data    = 16'h0000;
    if (fill_active_s) begin
      i_fill_valid = (owner_r == OWN_I);
      d_fill_valid = (owner_r == OWN_D);
      fill_data    = mem_rdata;
    end else begin
      i_fill_valid = 1'b0;
      d_fill_valid = 1'b0;
      fill_data    = 16'h0000;
    end
  end

  assign fill_idx = ret_cnt_r;

  // Main FSM with registered memory-side and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      owner_r     <= OWN_D;
      issue_cnt_r <= 4'd0;
      ret_cnt_r   <= 4'd0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_wdata   <= 16'h0000;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          issue_cnt_r <= 4'd0;
          ret_cnt_r   <= 4'd0;
          mem_wr      <= 1'b0;
          i_done      <= 1'b0;
          d_done      <= 1'b0;
          if (grant_d_s) begin
            owner_r <= OWN_D;
            busy    <= 1'b1;
            mem_en  <= 1'b1;
            if (d_we) begin
              // Single write goes out with its done pulse in the same cycle.
              state_r   <= DONE;
              mem_wr    <= 1'b1;
              mem_addr  <= d_addr & 16'hFFFE;
              mem_wdata <= d_wdata;
              d_done    <= 1'b1;
            end else begin
              state_r  <= ISSUE;
              mem_addr <= d_addr & BASE_MASK;
            end
          end else if (grant_i_s) begin
            owner_r  <= OWN_I;
            busy     <= 1'b1;
            mem_en   <= 1'b1;
            state_r  <= ISSUE;
            mem_addr <= i_addr & BASE_MASK;
          end else begin
            busy   <= 1'b0;
            mem_en <= 1'b0;
          end
        end
        ISSUE: begin
          if (fill_active_s) begin
            ret_cnt_r <= ret_cnt_r + 4'd1;
          end
          if (issue_cnt_r == LAST_IDX) begin
            state_r <= DRAIN;
            mem_en  <= 1'b0;
          end else begin
            issue_cnt_r <= issue_cnt_r + 4'd1;
            mem_addr    <= mem_addr + 16'd2;
          end
        end
        DRAIN: begin
          if (fill_active_s) begin
            if (ret_cnt_r == LAST_IDX) begin
              state_r   <= DONE;
              ret_cnt_r <= 4'd0;
              i_done    <= (owner_r == OWN_I);
              d_done    <= (owner_r == OWN_D);
            end else begin
              ret_cnt_r <= ret_cnt_r + 4'd1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          mem_en  <= 1'b0;
          mem_wr  <= 1'b0;
          i_done  <= 1'b0;
          d_done  <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          mem_en  <= 1'b0;
          mem_wr  <= 1'b0;
          i_done  <= 1'b0;
          d_done  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A table of request
// vectors is applied in turn; each fill's expected returned words are queued
// as the reads are issued and compared as the arbiter forwards them. Separate
// sequences cover a held D request during an I fill and reset mid-fill.
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;
  localparam int BLK     = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_fill_valid, d_fill_valid, i_done, d_done, busy;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  fill_idx;
  logic        mem_en, mem_wr, mem_rvalid;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .BLK_WORDS(BLK)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_done(i_done), .d_done(d_done), .busy(busy),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  // Memory model: fixed-latency read pipeline, data derived from address.
  function automatic logic [15:0] rd(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  logic [MEM_LAT-1:0] pipe_v = '0;
  logic [15:0]        pipe_a [MEM_LAT];
  logic               stray = 1'b0;

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[MEM_LAT-2:0], mem_en && !mem_wr};
    pipe_a[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end

  assign mem_rvalid = pipe_v[MEM_LAT-1] | stray;
  assign mem_rdata  = pipe_v[MEM_LAT-1] ? rd(pipe_a[MEM_LAT-1]) :
                      (stray ? 16'hDEAD : 16'h0000);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected returned words.
  typedef struct {
    logic        d;
    logic [3:0]  idx;
    logic [15:0] data;
  } ret_t;
  ret_t sb[$];

  always @(negedge clk) begin
    if (i_fill_valid || d_fill_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_fill: got idx %0h data %0h expected no return (t=%0t)",
                 fill_idx, fill_data, $time);
      end else begin
        ret_t e;
        e = sb.pop_front();
        chk("fill_owner", {i_fill_valid, d_fill_valid}, e.d ? 32'd1 : 32'd2);
        chk("fill_idx", fill_idx, e.idx);
        chk("fill_data", fill_data, e.data);
      end
    end
  end

  // Checks a fill already granted at the preceding rising edge.
  task automatic do_fill(input logic exp_d, input logic [15:0] base);
    logic [15:0] a;
    for (int k = 1; k <= BLK + MEM_LAT + 1; k++) begin
      @(negedge clk);
      chk("busy_fill", busy, 1);
      if (k <= BLK) begin
        a = base + 16'(2 * (k - 1));
        chk("issue_en", {mem_en, mem_wr}, 2'b10);
        chk("issue_addr", mem_addr, a);
        sb.push_back('{d: exp_d, idx: 4'(k - 1), data: rd(a)});
      end else begin
        chk("issue_en_off", mem_en, 0);
      end
      chk("fill_timing", exp_d ? d_fill_valid : i_fill_valid,
          (k >= MEM_LAT + 1 && k <= BLK + MEM_LAT) ? 1 : 0);
      chk("fill_other", exp_d ? i_fill_valid : d_fill_valid, 0);
      chk("done_owner", exp_d ? d_done : i_done, (k == BLK + MEM_LAT + 1) ? 1 : 0);
      chk("done_other", exp_d ? i_done : d_done, 0);
    end
    chk("sb_empty", sb.size(), 0);
    if (exp_d) d_req = 1'b0;
    else       i_req = 1'b0;
  endtask

  // Checks a D write granted at the preceding rising edge.
  task automatic do_write(input logic [15:0] a, input logic [15:0] wd);
    @(negedge clk);
    chk("wr_en", {mem_en, mem_wr}, 2'b11);
    chk("wr_addr", mem_addr, a);
    chk("wr_data", mem_wdata, wd);
    chk("wr_done", {d_done, i_done, busy}, 3'b101);
    d_req = 1'b0;
  endtask

  typedef struct {
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        exp_d;
    logic        exp_wr;
    logic [15:0] exp_addr;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic dr,
                              input logic dw, input logic [15:0] da, input logic [15:0] dd,
                              input logic ed, input logic ew, input logic [15:0] ea);
    vec_t v;
    v = '{ir, ia, dr, dw, da, dd, ed, ew, ea};
    return v;
  endfunction

  vec_t vecs [8];

  initial begin
    vecs[0] = mk(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1230);
    vecs[1] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0043, 16'hBEEF, 1'b1, 1'b1, 16'h0042);
    vecs[2] = mk(1'b1, 16'hFFF8, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFF0);
    vecs[3] = mk(1'b1, 16'h2000, 1'b1, 1'b0, 16'h3456, 16'h0000, 1'b1, 1'b0, 16'h3450);
`ifdef MEM_ARBITER_RR_EN
    vecs[4] = mk(1'b1, 16'h2000, 1'b1, 1'b0, 16'h3456, 16'h0000, 1'b0, 1'b0, 16'h2000);
`else
    vecs[4] = mk(1'b1, 16'h2000, 1'b1, 1'b0, 16'h3456, 16'h0000, 1'b1, 1'b0, 16'h3450);
`endif
    vecs[5] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h00F0);
    vecs[6] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 16'h1357, 1'b1, 1'b1, 16'hFFFE);
`ifdef MEM_ARBITER_RR_EN
    vecs[7] = mk(1'b1, 16'h4444, 1'b1, 1'b1, 16'h8888, 16'hAAAA, 1'b0, 1'b0, 16'h4440);
`else
    vecs[7] = mk(1'b1, 16'h4444, 1'b1, 1'b1, 16'h8888, 16'hAAAA, 1'b1, 1'b1, 16'h8888);
`endif

    rst_n = 1'b0;
    i_req = 1'b0; i_addr = 16'h0000;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    #12;
    chk("rst_outputs", {i_fill_valid, d_fill_valid, i_done, d_done, busy, mem_en, mem_wr}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_fill", {fill_data, fill_idx}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven transactions.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      i_req = vecs[v].i_req; i_addr = vecs[v].i_addr;
      d_req = vecs[v].d_req; d_we = vecs[v].d_we;
      d_addr = vecs[v].d_addr; d_wdata = vecs[v].d_wdata;
      @(posedge clk);
      if (vecs[v].exp_wr) do_write(vecs[v].exp_addr, vecs[v].d_wdata);
      else                do_fill(vecs[v].exp_d, vecs[v].exp_addr);
      @(negedge clk);
      chk("idle_after", {busy, mem_en, i_done, d_done}, 0);
      i_req = 1'b0; d_req = 1'b0;
    end

    // D fill held during an I fill: granted at the single IDLE edge after i_done.
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h5678;
    chk("hold_busy1", busy, 1);
    chk("hold_addr1", mem_addr, 16'h1230);
    sb.push_back('{d: 1'b0, idx: 4'd0, data: rd(16'h1230)});
    for (int k = 2; k <= BLK + MEM_LAT + 1; k++) begin
      @(negedge clk);
      chk("hold_busy", busy, 1);
      if (k <= BLK) sb.push_back('{d: 1'b0, idx: 4'(k - 1), data: rd(16'h1230 + 16'(2 * (k - 1)))});
      chk("hold_ddone", d_done, 0);
    end
    chk("hold_idone", i_done, 1);
    i_req = 1'b0;
    @(negedge clk);
    chk("hold_idle_gap", busy, 0);
    @(posedge clk);
    do_fill(1'b1, 16'h5670);
    @(negedge clk);
    chk("hold_idle_end", busy, 0);

    // Reset in cycle 6 of a fill; stale and stray returns must be ignored.
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h1234;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("rfill_addr", mem_addr, 16'h1230 + 16'(2 * (k - 1)));
      sb.push_back('{d: 1'b0, idx: 4'(k - 1), data: rd(16'h1230 + 16'(2 * (k - 1)))});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_req = 1'b0;
    sb.delete();
    #1;
    chk("rmid_outputs", {i_fill_valid, d_fill_valid, i_done, d_done, busy, mem_en, mem_wr}, 0);
    chk("rmid_addr", {mem_addr, mem_wdata}, 0);
    chk("rmid_fill", {fill_data, fill_idx}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      stray = (k == 4);
      @(negedge clk);
      chk("post_rst_quiet", {i_fill_valid, d_fill_valid, i_done, d_done, busy, mem_en}, 0);
    end
    @(posedge clk);
    #1;
    stray = 1'b0;

    // Normal operation resumes after the reset.
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0100;
    @(posedge clk);
    do_fill(1'b0, 16'h0100);
    @(negedge clk);
    chk("final_idle", {busy, mem_en}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 4, fixed memory read latency in cycles from issue to mem_rvalid.
REQ-002 SHALL have parameter BLK_WORDS, default 8, 16-bit words per block fill; power of 2, at most 16.
REQ-003 SHALL have ports, clock and reset first: clk in 1 (the one clock); rst_n in 1 (reset, asynchronous, active-low).
REQ-004 SHALL have ports i_req in 1, i_addr in 16: instruction-cache miss request and miss byte address.
REQ-005 SHALL have ports d_req in 1, d_we in 1, d_addr in 16, d_wdata in 16: data request; d_we=1 selects single-word write, d_we=0 selects block fill.
REQ-006 SHALL have ports i_fill_valid out 1, d_fill_valid out 1, fill_data out 16, fill_idx out 4: returned word and its word index within the block.
REQ-007 SHALL have ports i_done out 1, d_done out 1, busy out 1: one-cycle completion pulses and a busy indication.
REQ-008 SHALL have ports mem_en out 1, mem_wr out 1, mem_addr out 16, mem_wdata out 16, mem_rdata in 16, mem_rvalid in 1: pipelined main memory accepting one access per cycle.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE, plus a registered owner bit (I or D).
REQ-010 SHALL, in IDLE, sample requests at each rising edge; a granted request moves the FSM to ISSUE, or to DONE for a D write.
REQ-011 SHALL grant D when both requests are present in the same IDLE cycle (fixed priority, macro absent).
REQ-012 SHALL require requesters to hold req and addr stable until their done pulse; a request change before done is undefined.
REQ-013 SHALL form the fill base address as the requester's address with bits [log2(BLK_WORDS*2)-1:0] cleared; 0x1234 becomes 0x1230 at default.
REQ-014 SHALL, in ISSUE, assert mem_en=1 and mem_wr=0 for BLK_WORDS consecutive cycles, with mem_addr = base + 2*k for k = 0..BLK_WORDS-1; mem_addr wraps modulo 2^16.
REQ-015 SHALL move from ISSUE to DRAIN after the last issue, and from DRAIN to DONE in the cycle after the BLK_WORDS-th mem_rvalid.
REQ-016 SHALL count returns with a counter that drives fill_idx; fill_data = mem_rdata combinationally.
REQ-017 SHALL assert the owner's fill_valid combinationally when mem_rvalid=1 and the state is ISSUE or DRAIN.
REQ-018 SHALL ignore mem_rvalid in IDLE and DONE: no fill_valid is asserted.
REQ-019 SHALL perform a D write in the grant cycle's successor: mem_en=1, mem_wr=1, mem_addr = d_addr & 16'hFFFE, mem_wdata = d_wdata for exactly one cycle, with d_done in that same cycle.
REQ-020 SHALL, in DONE, pulse the owner's done signal for one cycle and return to IDLE; a new grant is possible at the next edge.
REQ-021 SHALL drive busy=1 in every state except IDLE.
REQ-022 SHALL give fill latency at default parameters as: grant edge E0; mem_en in cycles 1-8; rvalid in cycles 5-12; done in cycle 13.
REQ-023 SHALL drive mem_en=0 whenever no issue or write is taking place; mem_addr and mem_wdata are don't-care then.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force state IDLE, owner=D, counters 0, and all outputs 0.
REQ-025 SHALL abandon any in-flight fill or write when reset is asserted mid-operation; no done pulse is issued, and returns arriving after reset release are ignored per REQ-018.
REQ-026 SHALL evaluate the first grant at the first rising edge with rst_n=1.

Configuration
REQ-027 SHALL, when macro MEM_ARBITER_RR_EN is defined, resolve simultaneous requests round-robin: the requester not granted most recently wins, and after reset D wins first.
REQ-028 SHALL, when MEM_ARBITER_RR_EN is undefined, use fixed D priority per REQ-011.

Verification
REQ-029 SHALL cover: i_req=1, i_addr=0x1234 -> mem_addr 0x1230..0x123E in cycles 1-8; i_fill_valid with fill_idx 0..7 in cycles 5-12; i_done in cycle 13.
REQ-030 SHALL cover: d_req=1, d_we=1, d_addr=0x0043, d_wdata=0xBEEF -> one cycle with mem_en=1, mem_wr=1, addr 0x0042, data 0xBEEF; d_done in the same cycle.
REQ-031 SHALL cover: i_req and d_req (fill) asserted together twice back-to-back -> D served both times without the macro; D then I with MEM_ARBITER_RR_EN defined.
REQ-032 SHALL cover: i_addr=0xFFF8 -> mem_addr 0xFFF0..0xFFFE, with no wrap inside the block; base 0xFFF0.
REQ-033 SHALL cover: rst_n pulled low in cycle 6 of a fill -> all outputs 0 immediately; after release, stray mem_rvalid produces no fill_valid and no done.
REQ-034 SHALL cover: d_req held during an I fill -> d grant at the first IDLE edge after i_done, with busy=1 throughout except that single IDLE cycle.
